// File: rtl/result_edge_monitor_pkg.sv
// Shared types and defaults for the result edge monitor: FSM states, counter/window sizing
// and the saturating-counter ceiling.
package result_edge_monitor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam int CNT_W_DEF  = 8;
  localparam int WINDOW_DEF = 16;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/result_edge_monitor_if.sv
// Snapshot handshake bundle from the edge monitor to the status/CSR logic.
// Master presents valid/count/sat/drop; slave returns ready.
interface result_edge_monitor_if
  import result_edge_monitor_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEF
);

  logic                      snap_valid_o;
  logic                      snap_ready_i;
  logic [NUM_CH*CNT_W-1:0]   snap_count_o;
  logic [NUM_CH-1:0]         snap_sat_o;
  logic                      snap_drop_o;

  modport master (
    output snap_valid_o,
    output snap_count_o,
    output snap_sat_o,
    output snap_drop_o,
    input  snap_ready_i
  );

  modport slave (
    input  snap_valid_o,
    input  snap_count_o,
    input  snap_sat_o,
    input  snap_drop_o,
    output snap_ready_i
  );

endinterface

// File: rtl/result_edge_monitor_edge_sat_counter.sv
// Saturating per-channel edge counter; count/sat outputs already include this cycle's inc so
// the terminal cycle can export them while clr zeroes the registers. No backpressure.
module edge_sat_counter
  import result_edge_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] count_q;
  logic             sat_q;
  logic             at_max;

  assign at_max = (count_q == MAX);
  assign count  = (inc && !at_max) ? count_q + 1'b1 : count_q;
  assign sat    = sat_q | (inc & at_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count;
      sat_q   <= sat;
    end
  end

endmodule

// File: rtl/result_edge_monitor.sv
// Counts rising edges per result channel over fixed windows and emits a count snapshot 1 cycle
// after each window's terminal cycle; a snapshot arriving while one is held unaccepted is dropped and flagged.
module result_edge_monitor
  import result_edge_monitor_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    result_i,
  input  logic                 enable_i,
  result_edge_monitor_if.master snap
);

  localparam int              WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  state_e                   state_q;
  logic [NUM_CH-1:0]        prev_q;
  logic [NUM_CH-1:0]        rise;
  logic [WIN_W-1:0]         win_q, win_d;
  logic [NUM_CH*CNT_W-1:0]  cnt_now;
  logic [NUM_CH-1:0]        sat_now;
  logic                     terminal, load;

  logic                     valid_q;
  logic [NUM_CH*CNT_W-1:0]  count_q;
  logic [NUM_CH-1:0]        sat_q;
  logic                     drop_q;
  logic                     pend_drop_q;

  assign rise     = result_i & ~prev_q;
  assign terminal = enable_i && (win_q == WIN_LAST);
  // A held snapshot may be replaced only when it is being accepted in the same cycle.
  assign load     = terminal && (!valid_q || snap.snap_ready_i);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (rise[g] & enable_i),
      .clr   (terminal),
      .count (cnt_now[g*CNT_W +: CNT_W]),
      .sat   (sat_now[g])
    );
  end

  always_comb begin
    win_d = win_q;
    if (enable_i) win_d = terminal ? '0 : win_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      win_q       <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
      sat_q       <= '0;
      drop_q      <= 1'b0;
      pend_drop_q <= 1'b0;
    end else begin
      prev_q <= result_i;
      win_q  <= win_d;
      case (state_q)
        IDLE:    if (enable_i)  state_q <= COUNT;
        COUNT:   if (!enable_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (load) begin
        valid_q     <= 1'b1;
        count_q     <= cnt_now;
        sat_q       <= sat_now;
        drop_q      <= pend_drop_q;
        pend_drop_q <= 1'b0;
      end else begin
        if (terminal) pend_drop_q <= 1'b1;
        if (valid_q && snap.snap_ready_i) valid_q <= 1'b0;
      end
    end
  end

  assign snap.snap_valid_o = valid_q;
  assign snap.snap_count_o = count_q;
  assign snap.snap_sat_o   = sat_q;
  assign snap.snap_drop_o  = drop_q;

endmodule

// File: tb/tb_result_edge_monitor.sv
// Directed bench: expected snapshots are queued as each window is driven and compared when presented.
module tb_result_edge_monitor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_b, enable_a, enable_b;
  logic [1:0] result_a, result_b;
  int         n_cmp = 0;
  int         n_err = 0;

  typedef struct packed {
    logic [7:0] cnt;
    logic [1:0] sat;
    logic       drop;
  } snap_t;

  snap_t qa[$];
  snap_t qb[$];

  result_edge_monitor_if #(.NUM_CH(2), .CNT_W(4)) snap_a ();
  result_edge_monitor_if #(.NUM_CH(2), .CNT_W(2)) snap_b ();

  result_edge_monitor #(.NUM_CH(2), .CNT_W(4), .WINDOW(8)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .result_i (result_a),
    .enable_i (enable_a),
    .snap     (snap_a.master)
  );

  result_edge_monitor #(.NUM_CH(2), .CNT_W(2), .WINDOW(8)) dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .result_i (result_b),
    .enable_i (enable_b),
    .snap     (snap_b.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [3:0] c0, input logic [3:0] c1, input logic [1:0] s, input logic d);
    snap_t e;
    e.cnt  = {c1, c0};
    e.sat  = s;
    e.drop = d;
    qa.push_back(e);
  endtask

  task automatic chk_snap_a(input string tag);
    snap_t e;
    chk({tag, "_vld"}, 32'(snap_a.snap_valid_o), 32'd1);
    n_cmp++;
    assert (qa.size() > 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed %0d queued expected >=1", tag, qa.size());
    end
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk({tag, "_cnt"},  32'(snap_a.snap_count_o), 32'(e.cnt));
      chk({tag, "_sat"},  32'(snap_a.snap_sat_o),   32'(e.sat));
      chk({tag, "_drop"}, 32'(snap_a.snap_drop_o),  32'(e.drop));
    end
  endtask

  task automatic chk_snap_b(input string tag);
    snap_t e;
    chk({tag, "_vld"}, 32'(snap_b.snap_valid_o), 32'd1);
    n_cmp++;
    assert (qb.size() > 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed %0d queued expected >=1", tag, qb.size());
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk({tag, "_cnt"},  32'(snap_b.snap_count_o), 32'(e.cnt[3:0]));
      chk({tag, "_sat"},  32'(snap_b.snap_sat_o),   32'(e.sat));
      chk({tag, "_drop"}, 32'(snap_b.snap_drop_o),  32'(e.drop));
    end
  endtask

  // One full enabled window on DUT A; ready optionally pulsed on its first and/or last cycle.
  task automatic run_window_a(input logic [7:0] c0, input logic [7:0] c1, input bit rf, input bit rl);
    for (int i = 0; i < 8; i++) begin
      result_a = {c1[i], c0[i]};
      snap_a.snap_ready_i = (i == 0 && rf) || (i == 7 && rl);
      tick();
      if (i == 0 && rf) chk("acc_drop", 32'(snap_a.snap_valid_o), 32'd0);
    end
    snap_a.snap_ready_i = 1'b0;
  endtask

  task automatic run_window_b(input logic [7:0] c0, input logic [7:0] c1, input bit rf);
    for (int i = 0; i < 8; i++) begin
      result_b = {c1[i], c0[i]};
      snap_b.snap_ready_i = (i == 0 && rf);
      tick();
    end
    snap_b.snap_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w1_c1;
    snap_t      eb;

    rst = 1'b1; rst_b = 1'b1;
    result_a = 2'b01; enable_a = 1'b1;
    result_b = 2'b00; enable_b = 1'b1;
    snap_a.snap_ready_i = 1'b0;
    snap_b.snap_ready_i = 1'b0;
    #2;
    chk("rst_vld",  32'(snap_a.snap_valid_o), 32'd0);
    chk("rst_cnt",  32'(snap_a.snap_count_o), 32'd0);
    chk("rst_sat",  32'(snap_a.snap_sat_o),   32'd0);
    chk("rst_drop", 32'(snap_a.snap_drop_o),  32'd0);
    tick();
    rst = 1'b0;

    // Window 1: ch0 high from reset release (one edge), ch1 pulsed three times.
    push_a(4'd1, 4'd3, 2'b00, 1'b0);
    w1_c1 = 8'b0010_1010;
    for (int i = 0; i < 8; i++) begin
      result_a = {w1_c1[i], 1'b1};
      tick();
      if (i == 6) chk("t1_lat", 32'(snap_a.snap_valid_o), 32'd0);
    end
    chk_snap_a("t1");

    // Edge only on the terminal cycle, then an empty window.
    push_a(4'd1, 4'd0, 2'b00, 1'b0);
    run_window_a(8'h80, 8'h00, 1'b1, 1'b0);
    chk_snap_a("t2");
    push_a(4'd0, 4'd0, 2'b00, 1'b0);
    run_window_a(8'h00, 8'h00, 1'b1, 1'b0);
    chk_snap_a("t2_next");

    // Two windows complete while the empty snapshot is held.
    run_window_a(8'b0101_0101, 8'h00, 1'b0, 1'b0);
    chk("t3_hold1_vld",  32'(snap_a.snap_valid_o), 32'd1);
    chk("t3_hold1_cnt",  32'(snap_a.snap_count_o), 32'd0);
    chk("t3_hold1_drop", 32'(snap_a.snap_drop_o),  32'd0);
    run_window_a(8'b0000_0011, 8'hFF, 1'b0, 1'b0);
    chk("t3_hold2_vld",  32'(snap_a.snap_valid_o), 32'd1);
    chk("t3_hold2_cnt",  32'(snap_a.snap_count_o), 32'd0);
    push_a(4'd1, 4'd0, 2'b00, 1'b1);
    run_window_a(8'h01, 8'h00, 1'b1, 1'b0);
    chk_snap_a("t3_drop");

    // Accept coincides with the next terminal cycle.
    push_a(4'd0, 4'd2, 2'b00, 1'b0);
    run_window_a(8'h00, 8'h11, 1'b0, 1'b1);
    chk_snap_a("t4");

    // Enable dropped for five cycles at window position 3.
    snap_a.snap_ready_i = 1'b1;
    result_a = 2'b01;
    tick();
    chk("t6_acc", 32'(snap_a.snap_valid_o), 32'd0);
    snap_a.snap_ready_i = 1'b0;
    result_a = 2'b00; tick();
    result_a = 2'b01; tick();
    enable_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      result_a = (i % 2 == 1) ? 2'b11 : 2'b00;
      tick();
    end
    chk("t6_frozen", 32'(snap_a.snap_valid_o), 32'd0);
    enable_a = 1'b1;
    result_a = 2'b01; tick();
    result_a = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_late", 32'(snap_a.snap_valid_o), 32'd0);
    push_a(4'd3, 4'd0, 2'b00, 1'b0);
    tick();
    chk_snap_a("t6_gate");

    // Reset mid-window while a snapshot is held.
    result_a = 2'b10; tick();
    result_a = 2'b00; tick();
    result_a = 2'b10; tick();
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_vld", 32'(snap_a.snap_valid_o), 32'd0);
    chk("t6_rst_cnt", 32'(snap_a.snap_count_o), 32'd0);
    chk("t6_rst_sat", 32'(snap_a.snap_sat_o),   32'd0);
    result_a = 2'b00;
    tick();
    rst = 1'b0;
    push_a(4'd0, 4'd2, 2'b00, 1'b0);
    run_window_a(8'h00, 8'h05, 1'b0, 1'b0);
    chk_snap_a("t6_post");

    // Saturation on the 2-bit counter instance.
    enable_a = 1'b0;
    tick();
    rst_b = 1'b0;
    chk("t5_rst_vld", 32'(snap_b.snap_valid_o), 32'd0);
    eb.cnt = 8'h0F; eb.sat = 2'b01; eb.drop = 1'b0;
    qb.push_back(eb);
    run_window_b(8'b0101_0101, 8'b0001_0101, 1'b0);
    chk_snap_b("t5_sat");
    eb.cnt = 8'h01; eb.sat = 2'b00; eb.drop = 1'b0;
    qb.push_back(eb);
    run_window_b(8'b0000_0010, 8'h00, 1'b1);
    chk_snap_b("t5_clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
